chien_search_sd_seq: RTL and testbench



---
 rtl/cs_sd_pkg.sv | 46 ++++
 rtl/cs_sd_engine.sv | 72 +++++++
 rtl/chien_search_sd_seq.sv | 129 ++++++++++++
 tb/tb_chien_search_sd_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cs_sd_pkg.sv
// Shared constants, state encoding and constant-multiply helpers for the
// soft-decision Chien search bank.
package cs_sd_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int pow2(input int n);
    return 1 << n;
  endfunction

  // value * alpha^k in GF(2^m); m is taken from the top set bit of prim.
  function automatic logic [31:0] gf_mul_alpha_pow(input logic [31:0] value,
                                                   input int k,
                                                   input logic [31:0] prim);
    int m;
    logic [31:0] v;
    m = 0;
    for (int b = 0; b < 32; b++)
      if (prim[b]) m = b;
    v = value;
    for (int n = 0; n < k; n++) begin
      v = v << 1;
      if (v[m]) v = v ^ prim;
    end
    return v;
  endfunction

  localparam int DEF_GF_LEN   = 10;
  localparam int DEF_CODE_LEN = 1023;
  localparam int DEF_P        = 4;
  localparam int DEF_T        = 3;
  localparam int DEF_SD       = 3;
  localparam int DEF_NUM_TP   = pow2(DEF_SD);
  localparam int DEF_CNT_LEN  = clog2(DEF_T + 2);
  localparam int DEF_POS_LEN  = clog2(DEF_CODE_LEN);
  localparam int DEF_STEPS    = (DEF_CODE_LEN + DEF_P - 1) / DEF_P;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

endpackage

// File: rtl/cs_sd_engine.sv
// One test pattern: locator registers, P lane evaluators with end-of-code
// masking, and a saturating root counter.
module cs_sd_engine
  import cs_sd_pkg::*;
#(
  parameter int GF_LEN    = 10,
  parameter int PRIM_POLY = 'h409,
  parameter int CODE_LEN  = 1023,
  parameter int P         = 4,
  parameter int T         = 3,
  parameter int POS_LEN   = 10,
  parameter int CNT_LEN   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       clr,
  input  logic                       step,
  input  logic [T:0][GF_LEN-1:0]     coef,
  input  logic [POS_LEN-1:0]         base,
  output logic [P-1:0]               flags,
  output logic [CNT_LEN-1:0]         cnt
);

  logic [T:0][GF_LEN-1:0] r, r_next;
  logic [P-1:0][GF_LEN-1:0] eval;
  logic [CNT_LEN-1:0] cnt_next;

  function automatic logic [GF_LEN-1:0] mul_const(input logic [GF_LEN-1:0] v, input int k);
    logic [31:0] w;
    w = gf_mul_alpha_pow(32'(v), k, 32'(PRIM_POLY));
    return w[GF_LEN-1:0];
  endfunction

  // Each step advances every coefficient by alpha^(j*P) so lane p of the
  // next step sees position base+P+p.
  always_comb begin
    r_next = '0;
    for (int j = 0; j <= T; j++) r_next[j] = mul_const(r[j], j * P);
  end

  always_comb begin
    eval  = '0;
    flags = '0;
    for (int p = 0; p < P; p++) begin
      for (int j = 0; j <= T; j++) eval[p] = eval[p] ^ mul_const(r[j], j * p);
      flags[p] = (eval[p] == '0) && (int'(base) + p < CODE_LEN);
    end
  end

  always_comb begin
    int sum;
    sum = int'(cnt) + $countones(flags);
    cnt_next = (sum > T + 1) ? CNT_LEN'(T + 1) : CNT_LEN'(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r   <= '0;
      cnt <= '0;
    end else if (load) begin
      r   <= coef;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (step) begin
      r   <= r_next;
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/chien_search_sd_seq.sv
// Sequenced soft-decision Chien search: load/run/done control, step counter,
// per-pattern pass compare and lowest-index pattern selection.
module chien_search_sd_seq
  import cs_sd_pkg::*;
#(
  parameter int GF_LEN         = 10,
  parameter int PRIM_POLY      = 'h409,
  parameter int CODE_LEN       = 1023,
  parameter int PARALLELISM    = 4,
  parameter int HD_CORRECTABLE = 3,
  parameter int SD_CORRECTABLE = 3
) (
  input  logic clk,
  input  logic in_ctr_Arst_n,
  input  logic in_valid,
  output logic out_ready,
  input  logic [pow2(SD_CORRECTABLE)*(HD_CORRECTABLE+1)*GF_LEN-1:0] in_init_coef,
  input  logic [pow2(SD_CORRECTABLE)*clog2(HD_CORRECTABLE+2)-1:0]    in_deg,
  input  logic in_ctr_en,
  input  logic in_ctr_abort,
  output logic [pow2(SD_CORRECTABLE)*PARALLELISM-1:0]                out_equal,
  output logic out_equal_valid,
  output logic [clog2(CODE_LEN)-1:0]                                 out_pos,
  output logic out_done,
  output logic [pow2(SD_CORRECTABLE)*clog2(HD_CORRECTABLE+2)-1:0]    out_errCnt,
  output logic [pow2(SD_CORRECTABLE)-1:0]                            out_pass_mask,
  output logic [SD_CORRECTABLE-1:0]                                  out_sel_idx,
  output logic out_sel_valid
);

  localparam int T         = HD_CORRECTABLE;
  localparam int P         = PARALLELISM;
  localparam int NUM_TP    = pow2(SD_CORRECTABLE);
  localparam int CNT_LEN   = clog2(T + 2);
  localparam int POS_LEN   = clog2(CODE_LEN);
  localparam int STEPS     = (CODE_LEN + P - 1) / P;
  localparam int LAST_BASE = (STEPS - 1) * P;
  localparam int COEF_W    = (T + 1) * GF_LEN;

  state_t state;
  logic [POS_LEN-1:0] base;
  logic [NUM_TP-1:0][CNT_LEN-1:0] deg, cnt;
  logic [NUM_TP-1:0][P-1:0] flags;
  logic [NUM_TP-1:0] pass;
  logic res_vld;
  logic accept, run_abort, step, last;

  assign out_ready = (state == S_IDLE);
  assign accept    = out_ready && in_valid && !in_ctr_abort;
  assign run_abort = (state == S_RUN) && in_ctr_abort;
  assign step      = (state == S_RUN) && in_ctr_en && !in_ctr_abort;
  assign last      = (base == POS_LEN'(LAST_BASE));

  for (genvar i = 0; i < NUM_TP; i++) begin : g_eng
    cs_sd_engine #(
      .GF_LEN(GF_LEN), .PRIM_POLY(PRIM_POLY), .CODE_LEN(CODE_LEN),
      .P(P), .T(T), .POS_LEN(POS_LEN), .CNT_LEN(CNT_LEN)
    ) u_eng (
      .clk   (clk),
      .rst_n (in_ctr_Arst_n),
      .load  (accept),
      .clr   (run_abort),
      .step  (step),
      .coef  (in_init_coef[i*COEF_W +: COEF_W]),
      .base  (base),
      .flags (flags[i]),
      .cnt   (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      state           <= S_IDLE;
      base            <= '0;
      deg             <= '0;
      res_vld         <= 1'b0;
      out_done        <= 1'b0;
      out_equal       <= '0;
      out_equal_valid <= 1'b0;
      out_pos         <= '0;
    end else begin
      out_done        <= 1'b0;
      out_equal_valid <= step;
      out_equal       <= step ? flags : '0;
      if (step) out_pos <= base;
      case (state)
        S_IDLE: if (accept) begin
          state   <= S_RUN;
          base    <= '0;
          deg     <= in_deg;
          res_vld <= 1'b0;
        end
        S_RUN: if (in_ctr_abort) begin
          state <= S_IDLE;
        end else if (in_ctr_en) begin
          base <= base + POS_LEN'(P);
          if (last) begin
            state    <= S_DONE;
            out_done <= 1'b1;
            res_vld  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counts and degrees are frozen after DONE, so results stay stable until reload.
  always_comb begin
    pass = '0;
    for (int i = 0; i < NUM_TP; i++)
      pass[i] = res_vld && (cnt[i] == deg[i]) && (int'(deg[i]) <= T);
  end

  always_comb begin
    out_sel_idx   = '0;
    out_sel_valid = 1'b0;
    for (int i = NUM_TP - 1; i >= 0; i--)
      if (pass[i]) begin
        out_sel_idx   = SD_CORRECTABLE'(i);
        out_sel_valid = 1'b1;
      end
  end

  assign out_errCnt    = cnt;
  assign out_pass_mask = pass;

endmodule

// File: tb/tb_chien_search_sd_seq.sv
// Directed bench: GF(16) locators with known roots, stall, abort, reset and
// saturation sequences.
module tb_chien_search_sd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [23:0] in_init_coef;
  logic [3:0]  in_deg;
  logic        in_ctr_en;
  logic        in_ctr_abort;
  logic [7:0]  out_equal;
  logic        out_equal_valid;
  logic [3:0]  out_pos;
  logic        out_done;
  logic [3:0]  out_errCnt;
  logic [1:0]  out_pass_mask;
  logic [0:0]  out_sel_idx;
  logic        out_sel_valid;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [23:0]     coef;
    logic [3:0]      deg;
    logic [3:0][7:0] flg;
    logic [3:0]      cnt;
    logic [1:0]      pass;
    logic            sel;
    logic            selv;
  } vec_t;

  vec_t tbl [4];

  chien_search_sd_seq #(
    .GF_LEN(4), .PRIM_POLY('h13), .CODE_LEN(15), .PARALLELISM(4),
    .HD_CORRECTABLE(2), .SD_CORRECTABLE(1)
  ) dut (
    .clk             (clk),
    .in_ctr_Arst_n   (rst_n),
    .in_valid        (in_valid),
    .out_ready       (out_ready),
    .in_init_coef    (in_init_coef),
    .in_deg          (in_deg),
    .in_ctr_en       (in_ctr_en),
    .in_ctr_abort    (in_ctr_abort),
    .out_equal       (out_equal),
    .out_equal_valid (out_equal_valid),
    .out_pos         (out_pos),
    .out_done        (out_done),
    .out_errCnt      (out_errCnt),
    .out_pass_mask   (out_pass_mask),
    .out_sel_idx     (out_sel_idx),
    .out_sel_valid   (out_sel_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic load_vec(input int v);
    @(negedge clk);
    in_init_coef = tbl[v].coef;
    in_deg       = tbl[v].deg;
    in_valid     = 1'b1;
    in_ctr_en    = 1'b1;
  endtask

  // Load vector v, optionally stall, and check every step plus the results.
  task automatic run_vec(input int v, input int stall_at, input int stall_len,
                         input int exp_done, input bit abort_done);
    int nstep;
    bit got;
    nstep = 0;
    got   = 1'b0;
    load_vec(v);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1) chk($sformatf("v%0d_ready_low", v), 32'(out_ready), 0);
      if (out_equal_valid) begin
        chk($sformatf("v%0d_pos%0d", v, nstep), 32'(out_pos), nstep * 4);
        if (nstep < 4) chk($sformatf("v%0d_flags%0d", v, nstep), 32'(out_equal), 32'(tbl[v].flg[nstep]));
        nstep++;
      end
      if (out_done) begin
        got = 1'b1;
        chk($sformatf("v%0d_done_cycle", v), k, exp_done);
        chk($sformatf("v%0d_nsteps", v), nstep, 4);
        chk($sformatf("v%0d_errcnt", v), 32'(out_errCnt), 32'(tbl[v].cnt));
        chk($sformatf("v%0d_pass", v), 32'(out_pass_mask), 32'(tbl[v].pass));
        chk($sformatf("v%0d_sel", v), 32'(out_sel_idx), 32'(tbl[v].sel));
        chk($sformatf("v%0d_selv", v), 32'(out_sel_valid), 32'(tbl[v].selv));
      end
      in_ctr_en = !(k >= stall_at && k < stall_at + stall_len);
    end
    in_ctr_en = 1'b1;
    if (!got) begin
      chk($sformatf("v%0d_done_timeout", v), 0, 1);
    end else begin
      in_ctr_abort = abort_done;
      @(negedge clk);
      in_ctr_abort = 1'b0;
      chk($sformatf("v%0d_ready_back", v), 32'(out_ready), 1);
      chk($sformatf("v%0d_done_1cyc", v), 32'(out_done), 0);
      @(negedge clk);
      chk($sformatf("v%0d_pass_hold", v), 32'(out_pass_mask), 32'(tbl[v].pass));
      chk($sformatf("v%0d_cnt_hold", v), 32'(out_errCnt), 32'(tbl[v].cnt));
    end
  endtask

  initial begin
    int ndone;
    // Locators: A=(B,2,1) roots at positions 2,5; W=(1,1,0) root at 0 (15 masked);
    // Z=all-zero flags every in-range position; D=(2,1,0) root at position 1.
    tbl[0] = '{coef: 24'h01112B, deg: 4'hA, flg: {8'h00, 8'h00, 8'h02, 8'h14},
               cnt: 4'h6, pass: 2'b01, sel: 1'b0, selv: 1'b1};
    tbl[1] = '{coef: 24'h12B011, deg: 4'hA, flg: {8'h00, 8'h00, 8'h20, 8'h41},
               cnt: 4'h9, pass: 2'b10, sel: 1'b1, selv: 1'b1};
    tbl[2] = '{coef: 24'h000000, deg: 4'hE, flg: {8'h77, 8'hFF, 8'hFF, 8'hFF},
               cnt: 4'hF, pass: 2'b00, sel: 1'b0, selv: 1'b0};
    tbl[3] = '{coef: 24'h12B012, deg: 4'h9, flg: {8'h00, 8'h00, 8'h20, 8'h42},
               cnt: 4'h9, pass: 2'b11, sel: 1'b0, selv: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_init_coef = '0; in_deg = '0;
    in_ctr_en = 1'b0; in_ctr_abort = 1'b0;
    #12;
    chk("rst_ready", 32'(out_ready), 1);
    chk("rst_outs", 32'({out_equal, out_equal_valid, out_pos, out_done}), 0);
    chk("rst_results", 32'({out_errCnt, out_pass_mask, out_sel_idx, out_sel_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) run_vec(v, 0, 0, 5, 1'b0);

    // Three stalled cycles after step 1 delay out_done by exactly three.
    run_vec(0, 3, 3, 8, 1'b0);

    // Abort asserted during DONE must not disturb results.
    run_vec(3, 0, 0, 5, 1'b1);

    // Abort while evaluating step 2.
    load_vec(0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); in_ctr_abort = 1'b1;
    @(negedge clk); in_ctr_abort = 1'b0;
    chk("abort_ready", 32'(out_ready), 1);
    chk("abort_cnt_clear", 32'(out_errCnt), 0);
    chk("abort_no_valid", 32'(out_equal_valid), 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_vec(0, 0, 0, 5, 1'b0);

    // Abort in IDLE beats a load request.
    @(negedge clk);
    in_init_coef = tbl[1].coef; in_deg = tbl[1].deg;
    in_valid = 1'b1; in_ctr_abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_ctr_abort = 1'b0;
    chk("idle_abort_ready", 32'(out_ready), 1);
    @(negedge clk);
    chk("idle_abort_no_run", 32'({out_ready, out_equal_valid}), 32'b10);

    // Asynchronous reset mid-run.
    load_vec(2);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(out_errCnt), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(out_ready), 1);
    chk("mid_rst_outs", 32'({out_equal, out_equal_valid, out_pos, out_done}), 0);
    chk("mid_rst_results", 32'({out_errCnt, out_pass_mask, out_sel_idx, out_sel_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(1, 0, 0, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
